// File: rtl/kf8259_init_pkg.sv
// Shared types, word indices and word-order helpers for the KF8259 init sequencer.
// Word indices count up in bus order; W_END marks "no more words".
package kf8259_init_pkg;

    // Phase of a single word write cycle.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_HOST = 3'd1,
        ST_SETUP     = 3'd2,
        ST_STROBE    = 3'd3,
        ST_HOLD      = 3'd4,
        ST_GAP       = 3'd5
    } state_e;

    // Ownership of the 8259 port at the sequencing level.
    typedef enum logic [1:0] {
        SEQ_IDLE      = 2'd0,
        SEQ_WAIT_HOST = 2'd1,
        SEQ_RUN       = 2'd2
    } seq_e;

    localparam logic [2:0] W_ICW1 = 3'd0;
    localparam logic [2:0] W_ICW2 = 3'd1;
    localparam logic [2:0] W_ICW3 = 3'd2;
    localparam logic [2:0] W_ICW4 = 3'd3;
    localparam logic [2:0] W_OCW1 = 3'd4;
    localparam logic [2:0] W_END  = 3'd5;

    localparam logic A0_ICW1 = 1'b0;
    localparam logic A0_REST = 1'b1;

    function automatic logic word_a0(input logic [2:0] w);
        return (w == W_ICW1) ? A0_ICW1 : A0_REST;
    endfunction

    // sngl = ICW1[1], ic4 = ICW1[0]; ICW3 only for cascade, ICW4 only when requested.
    function automatic logic [2:0] next_word(input logic [2:0] cur,
                                             input logic       sngl,
                                             input logic       ic4);
        logic [2:0] nxt;
        nxt = W_END;
        case (cur)
            W_ICW1: nxt = W_ICW2;
            W_ICW2: nxt = !sngl ? W_ICW3 : (ic4 ? W_ICW4 : W_OCW1);
            W_ICW3: nxt = ic4 ? W_ICW4 : W_OCW1;
            W_ICW4: nxt = W_OCW1;
            default: nxt = W_END;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/kf8259_write_cycle_gen.sv
// One 8259 bus write: SETUP, STROBE (WR_PULSE clocks), HOLD, GAP (GAP clocks).
// A go accepted in the last GAP clock chains straight into the next SETUP.
module kf8259_write_cycle_gen
    import kf8259_init_pkg::*;
#(
    parameter int WR_PULSE = 2,
    parameter int GAP      = 1
) (
    input  logic       clock_i,
    input  logic       reset_n_i,
    input  logic       go_i,
    input  logic       addr_i,
    input  logic [7:0] data_i,
    output logic       cs_n_o,
    output logic       we_n_o,
    output logic       addr_o,
    output logic [7:0] data_o,
    output logic       cycle_done_o
);

    localparam int CNT_MAX = (WR_PULSE > GAP) ? WR_PULSE : GAP;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             addr_q, addr_d;
    logic [7:0]       data_q, data_d;
    logic             load;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        data_d       = data_q;
        cycle_done_o = 1'b0;
        load         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (go_i) begin
                    state_d = ST_SETUP;
                    load    = 1'b1;
                end
            end
            ST_SETUP: begin
                state_d = ST_STROBE;
                cnt_d   = CNT_W'(WR_PULSE - 1);
            end
            ST_STROBE: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                state_d = ST_GAP;
                cnt_d   = CNT_W'(GAP - 1);
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    cycle_done_o = 1'b1;
                    cnt_d        = '0;
                    if (go_i) begin
                        state_d = ST_SETUP;
                        load    = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Address/data only change on SETUP entry, so A0 is stable through HOLD.
        if (load) begin
            addr_d = addr_i;
            data_d = data_i;
        end
    end

    assign cs_n_o = !((state_q == ST_SETUP) || (state_q == ST_STROBE) || (state_q == ST_HOLD));
    assign we_n_o = (state_q != ST_STROBE);
    assign addr_o = addr_q;
    assign data_o = data_q;

endmodule

// File: rtl/kf8259_init_sequencer.sv
// Programs the KF8259 (ICW1..OCW1) after reset or on request and arbitrates
// the 8259 bus port between the host CPU interface and the sequencer.
module kf8259_init_sequencer
    import kf8259_init_pkg::*;
#(
    parameter logic [7:0] ICW1       = 8'h13,
    parameter logic [7:0] ICW2       = 8'h08,
    parameter logic [7:0] ICW3       = 8'h00,
    parameter logic [7:0] ICW4       = 8'h09,
    parameter logic [7:0] OCW1       = 8'hFF,
    parameter int         WR_PULSE   = 2,
    parameter int         GAP        = 1,
    parameter bit         AUTO_START = 1'b1
) (
    input  logic       clock_i,
    input  logic       reset_n_i,
    input  logic       start_i,
    output logic       busy_o,
    output logic       done_o,
    input  logic       host_chip_select_n_i,
    input  logic       host_read_enable_n_i,
    input  logic       host_write_enable_n_i,
    input  logic       host_address_i,
    input  logic [7:0] host_data_i,
    output logic       host_wait_o,
    output logic       pic_chip_select_n_o,
    output logic       pic_read_enable_n_o,
    output logic       pic_write_enable_n_o,
    output logic       pic_address_o,
    output logic [7:0] pic_data_o
);

    seq_e       seq_q, seq_d;
    logic [2:0] word_q, word_d;
    logic       done_q, done_d;
    logic       pending_q, pending_d;
    logic [2:0] word_nxt;
    logic       go;
    logic       go_addr;
    logic [7:0] go_data;

    logic       gen_cs_n, gen_we_n, gen_addr, gen_cycle_done;
    logic [7:0] gen_data;

    function automatic logic [7:0] word_data(input logic [2:0] w);
        logic [7:0] d;
        case (w)
            W_ICW1:  d = ICW1;
            W_ICW2:  d = ICW2;
            W_ICW3:  d = ICW3;
            W_ICW4:  d = ICW4;
            default: d = OCW1;
        endcase
        return d;
    endfunction

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            seq_q     <= SEQ_IDLE;
            word_q    <= W_ICW1;
            done_q    <= 1'b0;
            pending_q <= AUTO_START;
        end else begin
            seq_q     <= seq_d;
            word_q    <= word_d;
            done_q    <= done_d;
            pending_q <= pending_d;
        end
    end

    assign word_nxt = next_word(word_q, ICW1[1], ICW1[0]);

    always_comb begin
        seq_d     = seq_q;
        word_d    = word_q;
        done_d    = done_q;
        pending_d = pending_q;
        go        = 1'b0;
        case (seq_q)
            SEQ_IDLE: begin
                if (start_i || pending_q) begin
                    done_d    = 1'b0;
                    pending_d = 1'b0;
                    word_d    = W_ICW1;
                    // Never cut a host cycle already in flight.
                    if (!host_chip_select_n_i) begin
                        seq_d = SEQ_WAIT_HOST;
                    end else begin
                        seq_d = SEQ_RUN;
                        go    = 1'b1;
                    end
                end
            end
            SEQ_WAIT_HOST: begin
                if (host_chip_select_n_i) begin
                    seq_d = SEQ_RUN;
                    go    = 1'b1;
                end
            end
            SEQ_RUN: begin
                if (gen_cycle_done) begin
                    if (word_nxt == W_END) begin
                        seq_d  = SEQ_IDLE;
                        done_d = 1'b1;
                    end else begin
                        word_d = word_nxt;
                        go     = 1'b1;
                    end
                end
            end
            default: seq_d = SEQ_IDLE;
        endcase
    end

    assign go_addr = word_a0(word_d);
    assign go_data = word_data(word_d);

    kf8259_write_cycle_gen #(
        .WR_PULSE (WR_PULSE),
        .GAP      (GAP)
    ) u_wr_gen (
        .clock_i      (clock_i),
        .reset_n_i    (reset_n_i),
        .go_i         (go),
        .addr_i       (go_addr),
        .data_i       (go_data),
        .cs_n_o       (gen_cs_n),
        .we_n_o       (gen_we_n),
        .addr_o       (gen_addr),
        .data_o       (gen_data),
        .cycle_done_o (gen_cycle_done)
    );

    assign busy_o      = (seq_q == SEQ_RUN);
    assign done_o      = done_q;
    assign host_wait_o = busy_o;

    assign pic_chip_select_n_o  = busy_o ? gen_cs_n : host_chip_select_n_i;
    assign pic_read_enable_n_o  = busy_o ? 1'b1     : host_read_enable_n_i;
    assign pic_write_enable_n_o = busy_o ? gen_we_n : host_write_enable_n_i;
    assign pic_address_o        = busy_o ? gen_addr : host_address_i;
    assign pic_data_o           = busy_o ? gen_data : host_data_i;

endmodule

// File: tb/tb_kf8259_init_sequencer.sv
// Bench for kf8259_init_sequencer: bus-mux vector table, scoreboarded write
// cycles decoded by a small 8259 init model, and multi-cycle corner sequences.
module tb_kf8259_init_sequencer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset_n, start_a, start_b;
    logic       host_cs_n, host_rd_n, host_we_n, host_a0;
    logic [7:0] host_d;

    logic       busy_a, done_a, wait_a, pcs_a, prd_a, pwe_a, pa0_a;
    logic [7:0] pd_a;
    logic       busy_b, done_b, wait_b, pcs_b, prd_b, pwe_b, pa0_b;
    logic [7:0] pd_b;

    kf8259_init_sequencer dut_a (
        .clock_i(clock), .reset_n_i(reset_n), .start_i(start_a),
        .busy_o(busy_a), .done_o(done_a),
        .host_chip_select_n_i(host_cs_n), .host_read_enable_n_i(host_rd_n),
        .host_write_enable_n_i(host_we_n), .host_address_i(host_a0), .host_data_i(host_d),
        .host_wait_o(wait_a),
        .pic_chip_select_n_o(pcs_a), .pic_read_enable_n_o(prd_a),
        .pic_write_enable_n_o(pwe_a), .pic_address_o(pa0_a), .pic_data_o(pd_a)
    );

    kf8259_init_sequencer #(.ICW1(8'h10), .AUTO_START(1'b0)) dut_b (
        .clock_i(clock), .reset_n_i(reset_n), .start_i(start_b),
        .busy_o(busy_b), .done_o(done_b),
        .host_chip_select_n_i(host_cs_n), .host_read_enable_n_i(host_rd_n),
        .host_write_enable_n_i(host_we_n), .host_address_i(host_a0), .host_data_i(host_d),
        .host_wait_o(wait_b),
        .pic_chip_select_n_o(pcs_b), .pic_read_enable_n_o(prd_b),
        .pic_write_enable_n_o(pwe_b), .pic_address_o(pa0_b), .pic_data_o(pd_b)
    );

    logic       sel;
    logic       mon_busy, mon_done, mon_cs, mon_we, mon_a0;
    logic [7:0] mon_d;
    always_comb begin
        mon_busy = sel ? busy_b : busy_a;
        mon_done = sel ? done_b : done_a;
        mon_cs   = sel ? pcs_b  : pcs_a;
        mon_we   = sel ? pwe_b  : pwe_a;
        mon_a0   = sel ? pa0_b  : pa0_a;
        mon_d    = sel ? pd_b   : pd_a;
    end

    typedef struct packed { logic a0; logic [7:0] d; } wr_t;
    wr_t exp_q[$];

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Minimal 8259 init-word decoder driven by whatever the pic_* bus latches.
    logic [7:0] m_icw1, m_mask;
    int m_step, n_icw1, n_icw24, n_icw3, n_ocw1;

    task automatic model_clear();
        m_icw1 = 8'h00; m_mask = 8'h00; m_step = 0;
        n_icw1 = 0; n_icw24 = 0; n_icw3 = 0; n_ocw1 = 0;
    endtask

    task automatic model_write(input logic a0, input logic [7:0] d);
        if (!a0 && d[4]) begin
            m_icw1 = d; n_icw1++; m_step = 1;
        end else if (a0) begin
            case (m_step)
                1: begin n_icw24++; m_step = !m_icw1[1] ? 2 : (m_icw1[0] ? 3 : 0); end
                2: begin n_icw3++;  m_step = m_icw1[0] ? 3 : 0; end
                3: begin n_icw24++; m_step = 0; end
                default: begin m_mask = d; n_ocw1++; end
            endcase
        end
    endtask

    task automatic push(input logic a0, input logic [7:0] d);
        exp_q.push_back('{a0: a0, d: d});
    endtask

    logic prev_we = 1'b1, prev_cs = 1'b1, prev_busy = 1'b0;
    int low_cnt = 0, gap_cnt = 0, busy_cnt = 0;

    always @(negedge clock) begin : monitor
        wr_t e;
        if (!prev_we && mon_we && !mon_cs) begin
            if (mon_busy) check("we_low_clocks", low_cnt, 2);
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_write actual a0=%0b data=%0h required=no write", mon_a0, mon_d);
            end else begin
                e = exp_q.pop_front();
                check("write_word", {mon_a0, mon_d}, {e.a0, e.d});
            end
            model_write(mon_a0, mon_d);
        end
        if (!mon_we && !mon_cs) low_cnt++; else low_cnt = 0;

        if (mon_busy && prev_busy && prev_cs && !mon_cs) check("cs_gap_clocks", gap_cnt, 1);
        if (!mon_busy || !mon_cs) gap_cnt = 0; else gap_cnt++;

        if (mon_busy) busy_cnt++;
        else if (prev_busy) begin
            if (reset_n) begin
                check("busy_clocks", busy_cnt, 20);
                check("done_at_busy_fall", mon_done, 1);
            end
            busy_cnt = 0;
        end
        prev_we = mon_we; prev_cs = mon_cs; prev_busy = mon_busy;
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic wait_seq(input string name);
        int n = 0;
        while (!mon_busy && n < 100) begin tick(); n++; end
        while (mon_busy && n < 100) begin tick(); n++; end
        checks++;
        if (n >= 100 || mon_done !== 1'b1) begin
            failures++;
            $display("FAIL %s_complete actual busy=%0b done=%0b cycles=%0d required done=1 within 100",
                     name, mon_busy, mon_done, n);
        end
    endtask

    typedef struct {
        logic cs, rd, we, a0;
        logic [7:0] d;
        logic [11:0] exp;
    } vec_t;

    initial begin
        vec_t vt[5];
        int n;
        int bad;
        vt[0] = '{cs: 1'b0, rd: 1'b0, we: 1'b1, a0: 1'b1, d: 8'hA5, exp: 12'h3A5};
        vt[1] = '{cs: 1'b0, rd: 1'b1, we: 1'b1, a0: 1'b0, d: 8'h3C, exp: 12'h63C};
        vt[2] = '{cs: 1'b1, rd: 1'b1, we: 1'b0, a0: 1'b1, d: 8'hFF, exp: 12'hDFF};
        vt[3] = '{cs: 1'b1, rd: 1'b0, we: 1'b1, a0: 1'b0, d: 8'h81, exp: 12'hA81};
        vt[4] = '{cs: 1'b1, rd: 1'b1, we: 1'b1, a0: 1'b0, d: 8'h00, exp: 12'hE00};

        reset_n = 1'b0; start_a = 1'b0; start_b = 1'b0; sel = 1'b0;
        host_cs_n = 1'b1; host_rd_n = 1'b1; host_we_n = 1'b1; host_a0 = 1'b0; host_d = 8'h00;
        model_clear();
        repeat (3) tick();

        check("reset_busy_a", busy_a, 0);
        check("reset_done_a", done_a, 0);
        check("reset_wait_a", wait_a, 0);
        check("reset_busy_b", busy_b, 0);
        check("reset_pic_cs_a", pcs_a, 1);
        check("reset_pic_we_a", pwe_a, 1);

        // Auto start with defaults: ICW1, ICW2, ICW4, OCW1.
        push(1'b0, 8'h13); push(1'b1, 8'h08); push(1'b1, 8'h09); push(1'b1, 8'hFF);
        reset_n = 1'b1;
        wait_seq("auto_start");
        check("auto_queue_empty", exp_q.size(), 0);
        check("auto_n_icw1", n_icw1, 1);
        check("auto_n_icw2_4", n_icw24, 2);
        check("auto_n_icw3", n_icw3, 0);
        check("auto_mask", m_mask, 8'hFF);

        // Idle pass-through table.
        for (int i = 0; i < 5; i++) begin
            tick();
            host_cs_n = vt[i].cs; host_rd_n = vt[i].rd; host_we_n = vt[i].we;
            host_a0 = vt[i].a0; host_d = vt[i].d;
            #1;
            check("passthru_vec", {pcs_a, prd_a, pwe_a, pa0_a, pd_a}, vt[i].exp);
            check("passthru_wait", wait_a, 0);
        end

        // Host OCW1 write while idle.
        push(1'b1, 8'h5A);
        tick();
        host_cs_n = 1'b0; host_a0 = 1'b1; host_d = 8'h5A; host_we_n = 1'b0; host_rd_n = 1'b1;
        #1;
        check("host_wr_pic_we", pwe_a, 0);
        check("host_wr_pic_data", pd_a, 8'h5A);
        check("host_wr_wait", wait_a, 0);
        tick(); tick();
        host_we_n = 1'b1;
        tick();
        host_cs_n = 1'b1; host_a0 = 1'b0; host_d = 8'h00;
        tick();
        check("host_wr_mask", m_mask, 8'h5A);
        check("host_wr_queue_empty", exp_q.size(), 0);

        // Cascade, no IC4: ICW3 sent, ICW4 never.
        sel = 1'b1;
        model_clear();
        tick();
        push(1'b0, 8'h10); push(1'b1, 8'h08); push(1'b1, 8'h00); push(1'b1, 8'hFF);
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        wait_seq("cascade");
        check("casc_queue_empty", exp_q.size(), 0);
        check("casc_n_icw3", n_icw3, 1);
        check("casc_n_icw2_4", n_icw24, 1);
        check("casc_n_ocw1", n_ocw1, 1);
        sel = 1'b0;
        model_clear();
        tick();

        // Host cycle in flight at start: held off until chip select rises.
        push(1'b0, 8'h13); push(1'b1, 8'h08); push(1'b1, 8'h09); push(1'b1, 8'hFF);
        host_cs_n = 1'b0; host_rd_n = 1'b0; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (busy_a !== 1'b0 || pcs_a !== 1'b0 || prd_a !== 1'b0 || done_a !== 1'b0 || wait_a !== 1'b0) bad++;
            tick();
        end
        check("wait_host_passthru_bad_clocks", bad, 0);
        host_cs_n = 1'b1; host_rd_n = 1'b1;
        tick();
        check("wait_host_setup_busy", busy_a, 1);
        check("wait_host_setup_cs", pcs_a, 0);
        check("wait_host_setup_we", pwe_a, 1);
        wait_seq("wait_host");
        check("wait_host_queue_empty", exp_q.size(), 0);

        // Start while busy is ignored.
        push(1'b0, 8'h13); push(1'b1, 8'h08); push(1'b1, 8'h09); push(1'b1, 8'hFF);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (6) tick();
        check("busy_at_word2", busy_a, 1);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        wait_seq("restart_ignored");
        check("restart_queue_empty", exp_q.size(), 0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (busy_a !== 1'b0 || done_a !== 1'b1) bad++;
            tick();
        end
        check("no_second_run", bad, 0);

        // Reset during the ICW2 strobe, then restart from ICW1.
        model_clear();
        push(1'b0, 8'h13); push(1'b1, 8'h08); push(1'b1, 8'h09); push(1'b1, 8'hFF);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        n = 0;
        while (!(busy_a === 1'b1 && pwe_a === 1'b0 && pa0_a === 1'b1) && n < 50) begin tick(); n++; end
        check("icw2_strobe_reached", (n < 50), 1);
        reset_n = 1'b0;
        #1;
        check("midrst_pic_cs", pcs_a, 1);
        check("midrst_pic_we", pwe_a, 1);
        check("midrst_busy", busy_a, 0);
        check("midrst_done", done_a, 0);
        check("midrst_words_left", exp_q.size(), 3);
        exp_q.delete();
        model_clear();
        push(1'b0, 8'h13); push(1'b1, 8'h08); push(1'b1, 8'h09); push(1'b1, 8'hFF);
        tick(); tick();
        reset_n = 1'b1;
        wait_seq("after_reset");
        check("after_reset_queue_empty", exp_q.size(), 0);
        check("after_reset_n_icw1", n_icw1, 1);
        check("after_reset_mask", m_mask, 8'hFF);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule

// File: doc/kf8259_init_sequencer.md
Name: kf8259_init_sequencer

Overview:
Bus-master controller that programs the KF8259 interrupt controller after reset, or on request. It issues the ICW1, ICW2, optional ICW3, optional ICW4 and OCW1 write cycles in the exact chip-select/write-strobe shape the 8259 bus interface latches. It also arbitrates the 8259 bus port between the host CPU interface and itself. It sits between the CPU bus decoder and the 8259 instance in the PC/XT chipset.

Parameters:
ICW1, 8'h13, initial command word 1 (bit1 SNGL, bit0 IC4 control the sequence; bit4 must be 1)
ICW2, 8'h08, vector base
ICW3, 8'h00, cascade word (sent only when ICW1[1]=0)
ICW4, 8'h09, mode word (sent only when ICW1[0]=1)
OCW1, 8'hFF, initial interrupt mask
WR_PULSE, 2, write_enable_n low time in clocks (>=1)
GAP, 1, idle clocks with chip_select_n high between words (>=1)
AUTO_START, 1, 1 = start a sequence automatically on the first clock after reset release

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request to (re)program the 8259
busy  out  1  sequencer owns the 8259 bus
done  out  1  sticky; set when the last word completes, cleared by an accepted start or reset
host_chip_select_n  in  1  CPU-side chip select
host_read_enable_n  in  1  CPU-side read strobe
host_write_enable_n  in  1  CPU-side write strobe
host_address  in  1  CPU-side A0
host_data  in  8  CPU-side write data
host_wait  out  1  high while busy; CPU bus logic must extend or hold off its cycle
pic_chip_select_n  out  1  to 8259 chip_select_n
pic_read_enable_n  out  1  to 8259 read_enable_n
pic_write_enable_n  out  1  to 8259 write_enable_n
pic_address  out  1  to 8259 address (A0)
pic_data  out  8  to 8259 data_bus_in

Behaviour:
- Reset (async, reset_n=0): state IDLE, busy=0, done=0, word index=0, counters=0. The sequencer's own bus drives idle: cs_n=1, we_n=1, address=0, data=0. Reset mid-sequence abandons the sequence. If AUTO_START=1, the whole sequence restarts from ICW1 after release.
- Bus mux: when busy=0, the pic_* outputs are a combinational pass-through of the host_* inputs. When busy=1, pic_* come from the sequencer's registers, pic_read_enable_n=1, and the host strobes are ignored.
- Start acceptance: the sequencer accepts start (or the AUTO_START pending flag) only in IDLE. Start while busy is ignored. done clears on acceptance.
- Host-cycle protection: if host_chip_select_n=0 at acceptance, go to WAIT_HOST. Stay there until host_chip_select_n=1; busy stays 0 and the host cycle is never cut. Otherwise go directly to SETUP. busy=1 from the cycle after leaving IDLE/WAIT_HOST.
- Word list, in order, with A0 value:
  - ICW1 (A0=0)
  - ICW2 (A0=1)
  - ICW3 (A0=1, skipped if ICW1[1]=1)
  - ICW4 (A0=1, skipped if ICW1[0]=0)
  - OCW1 (A0=1)
- Per-word cycle; address and data are registered and stable from SETUP through HOLD:
  - SETUP: 1 clock, cs_n=0, we_n=1.
  - STROBE: WR_PULSE clocks, cs_n=0, we_n=0.
  - HOLD: 1 clock, cs_n=0, we_n=1. The 8259 detects the we_n rising edge here against a one-cycle-delayed A0, so A0 must not change.
  - GAP: GAP clocks, cs_n=1.
  - Then advance to the next word. After the final GAP, go to IDLE with busy=0 and done=1 in the same cycle.
- Clocks per word = 2 + WR_PULSE + GAP. Defaults: 5 clocks/word, 4 words (ICW3 skipped) = 20 clocks of busy.
- Counters: 3-bit word index and a pulse counter sized to cover max(WR_PULSE, GAP). Both reload at every state entry.

Decomposition:
- Package kf8259_init_pkg:
  - state enum (IDLE, WAIT_HOST, SETUP, STROBE, HOLD, GAP)
  - word index constants (W_ICW1..W_OCW1)
  - per-word A0 constant
  - function returning the next valid word index given ICW1 bits
- One natural sub-module, kf8259_write_cycle_gen. It runs SETUP/STROBE/HOLD/GAP for one word from a go pulse plus address and data, and returns a cycle_done pulse. The top level holds the word sequencing, arbitration and bus mux.

Test Plan:
- Defaults, AUTO_START=1, release reset -> four write cycles: 8'h13@A0=0, 8'h08@A0=1, 8'h09@A0=1, 8'hFF@A0=1. Each has we_n low exactly 2 clocks and cs_n high 1 clock between words. busy high 20 clocks, then done=1. KF8259 model shows ICW1, ICW2_4 x2 and OCW1 strobes decoded correctly.
- ICW1=8'h10 (cascade, no IC4) -> words 8'h10, ICW2, ICW3=8'h00, OCW1. ICW4 is never driven.
- Host holds host_chip_select_n=0 for 6 clocks when start pulses -> busy stays 0 and the host cycle passes through unchanged. SETUP begins the clock after host_chip_select_n rises.
- start pulsed while busy at word 2 -> ignored; the sequence completes normally with a single done assertion.
- reset_n asserted during STROBE of ICW2 -> pic_chip_select_n=1, pic_write_enable_n=1 immediately, busy=0, done=0. After release, the sequence restarts at ICW1.
- Host write of OCW1 8'h5A while idle -> appears combinationally on pic_*. host_wait=0. The KF8259 mask register reads back 8'h5A.
